// File: rtl/hit_bitmap_storage_pkg.sv
// Shared types and width helpers for the hit bitmap storage block.
package hit_storage_pkg;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits for single-entry sets
  function automatic int idxBits(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  function automatic int countBits(input int depth, input int width);
    return clog2(depth * width) + 1;
  endfunction

  typedef enum logic {SWEEP = 1'b0, RUN = 1'b1} storeState_e;

endpackage

// File: rtl/hit_bitmap_storage_if.sv
// Request/response bus between hit producers, the inquiry port and the storage.
interface hit_bitmap_storage_if #(
  parameter int WORDLENGTH  = 32,
  parameter int MEMORYDEPTH = 256,
  parameter int NUMCHANNELS = 2
);
  import hit_storage_pkg::*;

  localparam int WORDINDEXBITS   = clog2(MEMORYDEPTH);
  localparam int LETTERINDEXBITS = clog2(WORDLENGTH);
  localparam int COUNTBITS       = countBits(MEMORYDEPTH, WORDLENGTH);
  localparam int CHANBITS        = idxBits(NUMCHANNELS);

  logic [NUMCHANNELS-1:0]                 wrValid;
  logic [NUMCHANNELS-1:0]                 wrReady;
  logic [NUMCHANNELS*WORDINDEXBITS-1:0]   wrWordIndex;
  logic [NUMCHANNELS*LETTERINDEXBITS-1:0] wrLetterIndex;
  logic                                   inquiry;
  logic                                   inquiryReady;
  logic [WORDINDEXBITS-1:0]               inquiryWordIndex;
  logic [LETTERINDEXBITS-1:0]             inquiryLetterIndex;
  logic                                   respValid;
  logic                                   storedValue;
  logic                                   wrDoneValid;
  logic [CHANBITS-1:0]                    wrDoneChannel;
  logic                                   wrDoneWasSet;
  logic [COUNTBITS-1:0]                   hitCount;
  logic                                   clearStorage;
  logic                                   storageReady;

  modport master (
    output wrValid, wrWordIndex, wrLetterIndex, inquiry, inquiryWordIndex,
           inquiryLetterIndex, clearStorage,
    input  wrReady, inquiryReady, respValid, storedValue, wrDoneValid,
           wrDoneChannel, wrDoneWasSet, hitCount, storageReady
  );

  modport slave (
    input  wrValid, wrWordIndex, wrLetterIndex, inquiry, inquiryWordIndex,
           inquiryLetterIndex, clearStorage,
    output wrReady, inquiryReady, respValid, storedValue, wrDoneValid,
           wrDoneChannel, wrDoneWasSet, hitCount, storageReady
  );

endinterface

// File: rtl/hit_bitmap_storage_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the rotating pointer.
module rr_arbiter
  import hit_storage_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clock,
  input  logic         resetN,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = idxBits(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] nextPtr;

  // Descending scan so the requester closest to the pointer is the last write
  always_comb begin
    grant   = '0;
    nextPtr = ptr;
    for (int i = N - 1; i >= 0; i--) begin
      for (int j = 0; j < N; j++) begin
        if (req[j] && (j == (int'(ptr) + i) % N)) begin
          grant    = '0;
          grant[j] = 1'b1;
          nextPtr  = PW'((j + 1) % N);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN)      ptr <= '0;
    else if (advance) ptr <= nextPtr;
  end

endmodule

// File: rtl/hit_bitmap_storage.sv
// RAM-backed hit bitmap: multi-channel bit set, single-bit inquiry, hardware clear sweep.
module hit_bitmap_storage
  import hit_storage_pkg::*;
#(
  parameter int WORDLENGTH  = 32,
  parameter int MEMORYDEPTH = 256,
  parameter int NUMCHANNELS = 2
) (
  input logic                 clock,
  input logic                 resetN,
  hit_bitmap_storage_if.slave bus
);
  localparam int WORDINDEXBITS   = clog2(MEMORYDEPTH);
  localparam int LETTERINDEXBITS = clog2(WORDLENGTH);
  localparam int COUNTBITS       = countBits(MEMORYDEPTH, WORDLENGTH);
  localparam int CHANBITS        = idxBits(NUMCHANNELS);

  typedef struct packed {
    logic                       valid;
    logic                       isWrite;
    logic [CHANBITS-1:0]        chan;
    logic [WORDINDEXBITS-1:0]   word;
    logic [LETTERINDEXBITS-1:0] letter;
  } opReq_t;

  storeState_e state, nextState;
  logic [WORDINDEXBITS:0] sweepPtr;
  logic run, open, wrAdvance;
  logic [NUMCHANNELS-1:0] grant;
  opReq_t acc, s1;

  logic [WORDLENGTH-1:0]    mem [MEMORYDEPTH];
  logic [WORDLENGTH-1:0]    rdData, wrData;
  logic [WORDINDEXBITS-1:0] wrAddr;
  logic                     wrEn, oldBit;

  logic                 respValidQ, storedValueQ, wrDoneValidQ, wrDoneWasSetQ;
  logic [CHANBITS-1:0]  wrDoneChannelQ;
  logic [COUNTBITS-1:0] hitCountQ;

  // State machine: sweep pointer runs one past the last word before RUN
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state    <= SWEEP;
      sweepPtr <= '0;
    end else begin
      state    <= nextState;
      sweepPtr <= (bus.clearStorage || state == RUN) ? '0 : sweepPtr + 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    if (bus.clearStorage)
      nextState = SWEEP;
    else if (state == SWEEP && sweepPtr == (WORDINDEXBITS+1)'(MEMORYDEPTH))
      nextState = RUN;
  end

  assign run       = (state == RUN);
  assign open      = run && !bus.clearStorage;
  assign wrAdvance = open && !bus.inquiry;

  rr_arbiter #(.N(NUMCHANNELS)) uArb (
    .clock   (clock),
    .resetN  (resetN),
    .req     (bus.wrValid),
    .advance (wrAdvance),
    .grant   (grant)
  );

  assign bus.inquiryReady = open && bus.inquiry;
  assign bus.wrReady      = wrAdvance ? grant : '0;
  assign bus.storageReady = run;

  always_comb begin
    acc = '0;
    if (bus.inquiryReady) begin
      acc.valid  = 1'b1;
      acc.word   = bus.inquiryWordIndex;
      acc.letter = bus.inquiryLetterIndex;
    end else begin
      for (int c = 0; c < NUMCHANNELS; c++) begin
        if (bus.wrReady[c]) begin
          acc.valid   = 1'b1;
          acc.isWrite = 1'b1;
          acc.chan    = CHANBITS'(c);
          acc.word    = bus.wrWordIndex[c*WORDINDEXBITS +: WORDINDEXBITS];
          acc.letter  = bus.wrLetterIndex[c*LETTERINDEXBITS +: LETTERINDEXBITS];
        end
      end
    end
  end

  // Single write port shared by the clear sweep and the stage-2 read-modify-write
  assign oldBit = rdData[s1.letter];

  always_comb begin
    wrEn   = 1'b0;
    wrAddr = s1.word;
    wrData = rdData | (WORDLENGTH'(1) << s1.letter);
    if (state == SWEEP) begin
      wrEn   = resetN && !sweepPtr[WORDINDEXBITS];
      wrAddr = sweepPtr[WORDINDEXBITS-1:0];
      wrData = '0;
    end else if (s1.valid && s1.isWrite && !bus.clearStorage && resetN) begin
      wrEn = 1'b1;
    end
  end

  // Forwarding the word being written this edge keeps back-to-back hits coherent
  always_ff @(posedge clock) begin
    if (wrEn) mem[wrAddr] <= wrData;
    rdData <= (wrEn && wrAddr == acc.word) ? wrData : mem[acc.word];
  end

  always_ff @(posedge clock) begin
    if (!resetN || bus.clearStorage || !run) begin
      s1             <= '0;
      respValidQ     <= 1'b0;
      storedValueQ   <= 1'b0;
      wrDoneValidQ   <= 1'b0;
      wrDoneChannelQ <= '0;
      wrDoneWasSetQ  <= 1'b0;
      hitCountQ      <= '0;
    end else begin
      s1           <= acc;
      respValidQ   <= s1.valid && !s1.isWrite;
      wrDoneValidQ <= s1.valid && s1.isWrite;
      if (s1.valid && !s1.isWrite) storedValueQ <= oldBit;
      if (s1.valid && s1.isWrite) begin
        wrDoneChannelQ <= s1.chan;
        wrDoneWasSetQ  <= oldBit;
        if (!oldBit) hitCountQ <= hitCountQ + 1'b1;
      end
    end
  end

  assign bus.respValid     = respValidQ;
  assign bus.storedValue   = storedValueQ;
  assign bus.wrDoneValid   = wrDoneValidQ;
  assign bus.wrDoneChannel = wrDoneChannelQ;
  assign bus.wrDoneWasSet  = wrDoneWasSetQ;
  assign bus.hitCount      = hitCountQ;

endmodule

// File: tb/tb_hit_bitmap_storage.sv
// Directed bench for hit_bitmap_storage: vector table plus multi-cycle sequences.
module tb_hit_bitmap_storage;
  localparam int WB = 8;
  localparam int LB = 5;

  logic clock = 1'b0;
  logic resetN;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  hit_bitmap_storage_if #(.WORDLENGTH(32), .MEMORYDEPTH(256), .NUMCHANNELS(2)) bus ();

  hit_bitmap_storage #(.WORDLENGTH(32), .MEMORYDEPTH(256), .NUMCHANNELS(2)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  typedef struct {
    bit isW;
    int ch;
    int w;
    int l;
    bit expVal;
    int expHits;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.wrValid      = '0;
    bus.inquiry      = 1'b0;
    bus.clearStorage = 1'b0;
  endtask

  task automatic setWr(input int ch, input int w, input int l);
    bus.wrValid[ch]                = 1'b1;
    bus.wrWordIndex[ch*WB +: WB]   = w[WB-1:0];
    bus.wrLetterIndex[ch*LB +: LB] = l[LB-1:0];
  endtask

  task automatic setInq(input int w, input int l);
    bus.inquiry            = 1'b1;
    bus.inquiryWordIndex   = w[WB-1:0];
    bus.inquiryLetterIndex = l[LB-1:0];
  endtask

  // One operation in isolation; latency counts negedges after the idle cycle
  task automatic serialOp(input bit isW, input int ch, input int w, input int l,
                          output bit acc, output int lat, output bit val, output int chOut);
    @(negedge clock);
    idle();
    if (isW) setWr(ch, w, l);
    else     setInq(w, l);
    #1;
    acc = isW ? bus.wrReady[ch] : bus.inquiryReady;
    @(negedge clock);
    idle();
    lat = 0;
    val = 1'b0;
    chOut = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!(isW ? bus.wrDoneValid : bus.respValid) && lat < 6);
    val   = isW ? bus.wrDoneWasSet : bus.storedValue;
    chOut = int'(bus.wrDoneChannel);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[12];
    bit   acc, val, saw;
    int   lat, chOut, n0, n1;
    logic [31:0] word;

    vecs[0]  = '{1'b1, 0, 5,   3,  1'b0, 1};
    vecs[1]  = '{1'b0, 0, 5,   3,  1'b1, 1};
    vecs[2]  = '{1'b0, 0, 5,   4,  1'b0, 1};
    vecs[3]  = '{1'b1, 1, 5,   4,  1'b0, 2};
    vecs[4]  = '{1'b1, 0, 5,   4,  1'b1, 2};
    vecs[5]  = '{1'b0, 0, 5,   4,  1'b1, 2};
    vecs[6]  = '{1'b1, 1, 255, 31, 1'b0, 3};
    vecs[7]  = '{1'b0, 0, 255, 31, 1'b1, 3};
    vecs[8]  = '{1'b0, 0, 255, 30, 1'b0, 3};
    vecs[9]  = '{1'b1, 1, 0,   0,  1'b0, 4};
    vecs[10] = '{1'b0, 0, 0,   0,  1'b1, 4};
    vecs[11] = '{1'b0, 0, 1,   0,  1'b0, 4};

    // Reset and initial sweep
    resetN = 1'b0;
    idle();
    bus.wrWordIndex        = '0;
    bus.wrLetterIndex      = '0;
    bus.inquiryWordIndex   = '0;
    bus.inquiryLetterIndex = '0;
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    for (int m = 1; m <= 257; m++) begin
      @(negedge clock);
      if (m == 1) begin
        check("reset storageReady", bus.storageReady, 0);
        check("reset respValid", bus.respValid, 0);
        check("reset wrDoneValid", bus.wrDoneValid, 0);
        check("reset hitCount", bus.hitCount, 0);
        check("reset storedValue", bus.storedValue, 0);
      end
      if (m == 50) begin
        bus.wrValid = 2'b11;
        bus.inquiry = 1'b1;
        #1;
        check("sweep wrReady", bus.wrReady, 0);
        check("sweep inquiryReady", bus.inquiryReady, 0);
        idle();
      end
      if (m == 256) check("sweep end storageReady low", bus.storageReady, 0);
      if (m == 257) check("storageReady rise", bus.storageReady, 1);
    end

    // Vector table: isolated operations
    for (int i = 0; i < 12; i++) begin
      serialOp(vecs[i].isW, vecs[i].ch, vecs[i].w, vecs[i].l, acc, lat, val, chOut);
      check($sformatf("vec%0d accepted", i), acc, 1);
      check($sformatf("vec%0d latency", i), lat, 1);
      check($sformatf("vec%0d value", i), val, vecs[i].expVal);
      check($sformatf("vec%0d hitCount", i), bus.hitCount, vecs[i].expHits);
      if (vecs[i].isW) check($sformatf("vec%0d channel", i), chOut, vecs[i].ch);
    end

    // Round robin with both channels holding requests
    n0 = 0;
    n1 = 0;
    @(negedge clock);
    for (int k = 0; k < 6; k++) begin
      idle();
      setWr(0, 20 + n0, n0);
      setWr(1, 40 + n1, n1);
      #1;
      check($sformatf("rr grant %0d", k), bus.wrReady, (k % 2 == 0) ? 1 : 2);
      if (bus.wrReady[0]) n0++;
      if (bus.wrReady[1]) n1++;
      @(negedge clock);
    end
    idle();
    @(negedge clock);
    check("rr hitCount", bus.hitCount, 10);

    // Write then inquiry on the very next cycle
    @(negedge clock);
    setWr(0, 9, 3);
    #1;
    check("raw wrReady", bus.wrReady, 1);
    @(negedge clock);
    idle();
    setInq(9, 3);
    #1;
    check("raw inquiryReady", bus.inquiryReady, 1);
    @(negedge clock);
    check("raw wrDoneValid", bus.wrDoneValid, 1);
    check("raw wasSet", bus.wrDoneWasSet, 0);
    setInq(9, 4);
    @(negedge clock);
    idle();
    check("raw respValid", bus.respValid, 1);
    check("raw storedValue hit", bus.storedValue, 1);
    @(negedge clock);
    check("raw respValid 2", bus.respValid, 1);
    check("raw storedValue miss", bus.storedValue, 0);
    check("raw hitCount", bus.hitCount, 11);

    // Same address three times back to back
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (k >= 2) begin
        check($sformatf("dup wrDoneValid %0d", k - 2), bus.wrDoneValid, 1);
        check($sformatf("dup wasSet %0d", k - 2), bus.wrDoneWasSet, (k == 2) ? 0 : 1);
      end
      idle();
      if (k < 3) begin
        setWr(0, 7, 0);
        #1;
        check($sformatf("dup wrReady %0d", k), bus.wrReady, 1);
      end
    end
    check("dup hitCount", bus.hitCount, 12);
    word = '0;
    for (int b = 0; b < 32; b++) begin
      serialOp(1'b0, 0, 7, b, acc, lat, val, chOut);
      word[b] = val;
    end
    check("dup word 7", word, 32'h0000_0001);

    // Inquiry and write together: inquiry first
    @(negedge clock);
    setWr(1, 60, 1);
    setInq(60, 1);
    #1;
    check("prio inquiryReady", bus.inquiryReady, 1);
    check("prio wrReady held", bus.wrReady, 0);
    @(negedge clock);
    bus.inquiry = 1'b0;
    #1;
    check("prio wrReady next", bus.wrReady, 2);
    @(negedge clock);
    idle();
    check("prio respValid", bus.respValid, 1);
    check("prio storedValue", bus.storedValue, 0);
    @(negedge clock);
    check("prio wrDoneValid", bus.wrDoneValid, 1);
    check("prio wrDoneChannel", bus.wrDoneChannel, 1);
    check("prio hitCount", bus.hitCount, 13);

    // Clear with a write in flight
    @(negedge clock);
    setWr(0, 70, 2);
    #1;
    check("clr wrReady", bus.wrReady, 1);
    @(negedge clock);
    idle();
    bus.clearStorage = 1'b1;
    @(negedge clock);
    bus.clearStorage = 1'b0;
    check("clr wrDoneValid", bus.wrDoneValid, 0);
    check("clr storageReady", bus.storageReady, 0);
    check("clr hitCount", bus.hitCount, 0);
    saw = 1'b0;
    for (int m = 1; m <= 257; m++) begin
      @(negedge clock);
      if (bus.wrDoneValid || bus.respValid) saw = 1'b1;
      if (m == 256) check("clr sweep storageReady low", bus.storageReady, 0);
      if (m == 257) check("clr storageReady rise", bus.storageReady, 1);
    end
    check("clr no strobes", saw, 0);
    serialOp(1'b0, 0, 70, 2, acc, lat, val, chOut);
    check("clr read 70,2", val, 0);
    serialOp(1'b0, 0, 7, 0, acc, lat, val, chOut);
    check("clr read 7,0", val, 0);
    serialOp(1'b0, 0, 255, 31, acc, lat, val, chOut);
    check("clr read 255,31", val, 0);
    check("clr final hitCount", bus.hitCount, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
